// File: rtl/reset_sequencer.sv
// reset_sequencer
// Synchronises an asynchronous active-high reset request, optionally
// glitch-filters its deassertion, and releases NUM_CH active-low channel
// resets one at a time, STAGGER cycles apart, bit 0 first.
//
// Compile-time option: RSTSEQ_GLITCH_FILTER_EN
//   defined   - deassertion needs FILTER_CYCLES consecutive low samples
//   undefined - the filtered request is a plain register of the synced request

module reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int NUM_CH        = 4,
    parameter int STAGGER       = 16,
    parameter int FILTER_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_done,
    output logic [1:0]        seq_state
);

    // Timer holds 0..STAGGER-1; keep at least one bit so STAGGER = 1 elaborates.
    localparam int TW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    // idx can reach NUM_CH without wrapping.
    localparam int IW = $clog2(NUM_CH) + 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Reject illegal parameter values at elaboration time.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be 2 or more");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $error("NUM_CH must be 1 or more");
    end
    if (STAGGER < 1) begin : g_bad_stagger
        $error("STAGGER must be 1 or more");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("FILTER_CYCLES must be 1 or more");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    logic                   req_f_r;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [TW-1:0]          timer_r;
    logic [TW-1:0]          timer_next_s;
    logic [IW-1:0]          idx_r;
    logic [IW-1:0]          idx_next_s;
    logic [NUM_CH-1:0]      rst_n_r;
    logic [NUM_CH-1:0]      rst_n_next_s;
    logic                   done_r;
    logic                   done_next_s;

    // Synchroniser chain for the asynchronous request; reset fills it with "asserted".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rst_req};
        end
    end

    assign req_s = sync_r[SYNC_STAGES-1];

`ifdef RSTSEQ_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

    logic [CW-1:0] low_cnt_r;

    // Asymmetric filter: assert at once, deassert only after a long enough low run.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_cnt_r <= {CW{1'b0}};
            req_f_r   <= 1'b1;
        end else if (req_s) begin
            low_cnt_r <= {CW{1'b0}};
            req_f_r   <= 1'b1;
        end else if (low_cnt_r < CNT_MAX) begin
            low_cnt_r <= low_cnt_r + CW'(1);
            if ((low_cnt_r + CW'(1)) == CNT_MAX) begin
                req_f_r <= 1'b0;
            end else begin
                req_f_r <= req_f_r;
            end
        end else begin
            low_cnt_r <= low_cnt_r;
            req_f_r   <= req_f_r;
        end
    end
`else
    // Unfiltered: the request is simply registered in both directions.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_f_r <= 1'b1;
        end else begin
            req_f_r <= req_s;
        end
    end
`endif

    // State, timer, index and registered outputs all update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_HOLD;
            timer_r <= {TW{1'b0}};
            idx_r   <= {IW{1'b0}};
            rst_n_r <= {NUM_CH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            idx_r   <= idx_next_s;
            rst_n_r <= rst_n_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state and next-output logic; an asserted request always wins over a release.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        idx_next_s   = idx_r;
        rst_n_next_s = rst_n_r;
        done_next_s  = done_r;
        case (state_r)
            ST_HOLD: begin
                rst_n_next_s = {NUM_CH{1'b0}};
                done_next_s  = 1'b0;
                if (!req_f_r) begin
                    state_next_s = ST_RELEASE;
                    timer_next_s = {TW{1'b0}};
                    idx_next_s   = {IW{1'b0}};
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                if (req_f_r) begin
                    state_next_s = ST_HOLD;
                    rst_n_next_s = {NUM_CH{1'b0}};
                    done_next_s  = 1'b0;
                end else if (timer_r == TIMER_LAST) begin
                    timer_next_s = {TW{1'b0}};
                    idx_next_s   = idx_r + IW'(1);
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_r == IW'(i)) begin
                            rst_n_next_s[i] = 1'b1;
                        end else begin
                            rst_n_next_s[i] = rst_n_r[i];
                        end
                    end
                    if (idx_r == IDX_LAST) begin
                        state_next_s = ST_RUN;
                        done_next_s  = 1'b1;
                    end else begin
                        state_next_s = ST_RELEASE;
                    end
                end else begin
                    timer_next_s = timer_r + TW'(1);
                end
            end
            ST_RUN: begin
                if (req_f_r) begin
                    state_next_s = ST_HOLD;
                    rst_n_next_s = {NUM_CH{1'b0}};
                    done_next_s  = 1'b0;
                end else begin
                    done_next_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_HOLD;
                rst_n_next_s = {NUM_CH{1'b0}};
                done_next_s  = 1'b0;
            end
        endcase
    end

    assign rst_n_out = rst_n_r;
    assign seq_done  = done_r;
    assign seq_state = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Random and directed rst_req/reset stimulus checked against a timeline model:
// the filtered request is derived from the history of sampled inputs, and the
// outputs from the number of edges since the filtered request last fell.
// Follows RSTSEQ_GLITCH_FILTER_EN the same way the design does.

module tb_reset_sequencer;

    localparam int SYNC_STAGES   = 2;
    localparam int NUM_CH        = 4;
    localparam int STAGGER       = 16;
    localparam int FILTER_CYCLES = 4;
    localparam int MAXE          = 16384;

    logic              clk;
    logic              reset;
    logic              rst_req;
    logic [NUM_CH-1:0] rst_n_out;
    logic              seq_done;
    logic [1:0]        seq_state;

    int n_checks;
    int n_pass;

    bit req_in_a [0:MAXE-1];
    bit rst_at_a [0:MAXE-1];
    bit req_f_a  [0:MAXE-1];

    int          edge_n;
    int          last_one;
    logic [31:0] exp_rst;
    logic [31:0] exp_done;
    logic [31:0] exp_state;

    reset_sequencer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .NUM_CH       (NUM_CH),
        .STAGGER      (STAGGER),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rst_req  (rst_req),
        .rst_n_out(rst_n_out),
        .seq_done (seq_done),
        .seq_state(seq_state)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Synced request after edge t: any reset in the last N edges forces it high,
    // otherwise it is the rst_req value sampled N-1 edges earlier.
    function automatic bit req_s_at(input int t);
        for (int k = 0; k < SYNC_STAGES; k++) begin
            if ((t - k) < 1) return 1'b1;
            if (rst_at_a[t-k]) return 1'b1;
        end
        return req_in_a[t-SYNC_STAGES+1];
    endfunction

    // Filtered request after edge t.
    function automatic bit req_f_at(input int t);
        if (t < 1) return 1'b1;
        if (rst_at_a[t]) return 1'b1;
`ifdef RSTSEQ_GLITCH_FILTER_EN
        for (int j = 1; j <= FILTER_CYCLES; j++) begin
            if (req_s_at(t - j)) return 1'b1;
        end
        return 1'b0;
`else
        return req_s_at(t - 1);
`endif
    endfunction

    // Reference model and checker: predict each edge, compare half a cycle later.
    initial begin
        int k;
        int kc;
        edge_n     = 0;
        last_one   = 0;
        req_f_a[0] = 1'b1;
        forever begin
            @(posedge clk);
            edge_n++;
            if (edge_n >= MAXE) begin
                check_val("edge_budget", 32'(edge_n), 32'(MAXE - 1));
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $fatal(1, "edge budget exceeded");
            end
            req_in_a[edge_n] = rst_req;
            rst_at_a[edge_n] = reset;
            if (reset || req_f_a[edge_n-1]) begin
                exp_rst   = 32'd0;
                exp_done  = 32'd0;
                exp_state = 32'd0;
            end else begin
                // RELEASE was entered one edge after the request fell (at last_one+1).
                k  = (edge_n - last_one - 2) / STAGGER;
                kc = (k > NUM_CH) ? NUM_CH : k;
                exp_rst   = (32'd1 << kc) - 32'd1;
                exp_done  = (k >= NUM_CH) ? 32'd1 : 32'd0;
                exp_state = (k >= NUM_CH) ? 32'd2 : 32'd1;
            end
            req_f_a[edge_n] = req_f_at(edge_n);
            if (req_f_a[edge_n]) last_one = edge_n;
            @(negedge clk);
            check_val("rst_n_out", 32'(rst_n_out), exp_rst);
            check_val("seq_done",  32'(seq_done),  exp_done);
            check_val("seq_state", 32'(seq_state), exp_state);
        end
    end

    task automatic hold_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: directed scenarios, then random request/reset segments.
    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        rst_req  = 1'b1;
        hold_cycles(3);
        reset = 1'b0;
        hold_cycles(12);                           // reset values held
        rst_req = 1'b0; hold_cycles(90);           // full sequence
        rst_req = 1'b1; hold_cycles(1);            // 1-cycle glitch in RUN
        rst_req = 1'b0; hold_cycles(90);
        rst_req = 1'b1; hold_cycles(10);
        rst_req = 1'b0; hold_cycles(3);            // short low run in HOLD
        rst_req = 1'b1; hold_cycles(10);
        rst_req = 1'b0; hold_cycles(40);           // abort after bit 1
        rst_req = 1'b1; hold_cycles(6);
        rst_req = 1'b0; hold_cycles(90);           // full replay
        reset = 1'b1; hold_cycles(1);              // reset mid-RUN
        reset = 1'b0; hold_cycles(90);
        rst_req = 1'b0; hold_cycles(1);
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 4))
                0: begin rst_req = 1'b1; hold_cycles($urandom_range(1, 3)); end
                1: begin rst_req = 1'b0; hold_cycles($urandom_range(1, 6)); end
                2: begin rst_req = 1'b0; hold_cycles($urandom_range(20, 90)); end
                3: begin rst_req = 1'b1; hold_cycles($urandom_range(2, 8)); end
                default: begin
                    rst_req = 1'($urandom_range(0, 1));
                    reset   = 1'b1; hold_cycles(1);
                    reset   = 1'b0; hold_cycles($urandom_range(1, 40));
                end
            endcase
        end
        rst_req = 1'b0; hold_cycles(90);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset synchroniser and staggered release sequencer. An asynchronous external reset request enters the block, which synchronises and optionally glitch-filters it. The block then drives NUM_CH active-low reset outputs that all assert together and release one at a time, STAGGER cycles apart, so downstream blocks leave reset in a fixed order. It sits between the board-level reset request and every clocked subsystem on `clk`.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser flop count on `rst_req`; legal range 2 or more.
- NUM_CH, 4: number of sequenced reset outputs; legal range 1 or more.
- STAGGER, 16: cycles between successive channel releases; legal range 1 or more.
- FILTER_CYCLES, 4: consecutive low cycles required before a deassertion is accepted; legal range 1 or more.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high block reset.
- rst_req  in  1  asynchronous, active-high external reset request.
- rst_n_out  out  NUM_CH  active-low channel resets; bit 0 releases first.
- seq_done  out  1  high when all channels are released.
- seq_state  out  2  FSM state: 0 = HOLD, 1 = RELEASE, 2 = RUN.

## Operation
- **Synchroniser:** `rst_req` passes through SYNC_STAGES flops; the last flop is `req_s`.
- **Filter, asymmetric:**
  - Assertion is immediate: when `req_s` = 1, `req_f` becomes 1 on the next edge and the low counter clears.
  - Deassertion is filtered: while `req_s` = 0, the counter increments. `req_f` becomes 0 on the edge where the count reaches FILTER_CYCLES.
  - Any `req_s` = 1 clears the counter.
- **FSM states:**
  - HOLD: all `rst_n_out` = 0. If `req_f` = 0, go to RELEASE with timer = 0 and idx = 0.
  - RELEASE: the timer counts 0 to STAGGER-1. At timer = STAGGER-1, set `rst_n_out[idx]` = 1, increment idx and reset the timer. Releasing idx = NUM_CH-1 moves the FSM to RUN.
  - RUN: `seq_done` = 1.
- **Abort:** `req_f` = 1 in RELEASE or RUN moves the FSM to HOLD on the next edge. All outputs go to 0 together and `seq_done` goes to 0. A partial sequence is abandoned, never resumed.
- **Registers:** outputs are registered and update on the same edge as the state change. There is no combinational path from `rst_req` to any output.
- **Widths:** the timer is $clog2(STAGGER) bits and idx is $clog2(NUM_CH)+1 bits. Both are sized to avoid wrap. The timer never exceeds STAGGER-1.

## Timing
- **Reset values** (`reset` = 1, on the same edge):
  - sync flops all 1;
  - `req_f` = 1;
  - counter = 0;
  - FSM in HOLD;
  - `rst_n_out` = all 0;
  - `seq_done` = 0;
  - `seq_state` = 0.
- **`reset` priority:** `reset` overrides every other input, including mid-sequence. After `reset` falls, timing is identical to a `rst_req` deassertion seen at the first edge after reset.
- **Edge numbering:** N = SYNC_STAGES, F = FILTER_CYCLES. Edge 1 is the first edge that samples the new `rst_req` level.
- **Assertion latency:** `rst_n_out` = 0 at edge N+2.
- **Deassertion latency:**
  - `req_f` = 0 at edge N+F;
  - RELEASE entered at edge N+F+1;
  - channel i released at edge N+F+1+(i+1)·STAGGER;
  - `seq_done` rises on the same edge as the last channel.
- **Glitch:** a `req_s` low run shorter than F cycles produces no state change.
- **Simultaneous events:** if a release edge coincides with `req_f` = 1, the abort wins and no channel is released.

## Configuration
- RSTSEQ_GLITCH_FILTER_EN
  - **Defined:** the deassertion filter above is compiled in.
  - **Undefined:** the counter is removed and `req_f` is a plain register of `req_s` in both directions. Deassertion latency becomes `req_f` = 0 at edge N+1, RELEASE entered at N+2, and channel i released at N+2+(i+1)·STAGGER. Assertion latency is unchanged.
  - FILTER_CYCLES is ignored when the macro is undefined.

## Test plan
All scenarios use defaults (SYNC_STAGES = 2, NUM_CH = 4, STAGGER = 16, FILTER_CYCLES = 4) unless stated.
- **Reset values:** pulse `reset` with `rst_req` = 1 → `rst_n_out` = 4'b0000, `seq_done` = 0, `seq_state` = 0, held indefinitely.
- **Full sequence:** drop `rst_req` (filter enabled) → `rst_n_out` bits rise at edges 23, 39, 55, 71 in the order 0001, 0011, 0111, 1111. `seq_done` = 1 and `seq_state` = 2 at edge 71.
- **Glitch rejection:** in RUN, pulse `rst_req` high for 1 cycle → outputs 0000 at edge 4 and the sequence restarts. Separately, in HOLD, hold `rst_req` low for 3 cycles then high → `rst_n_out` stays 0000 and `seq_state` stays 0.
- **Mid-sequence abort:** raise `rst_req` right after bit 1 releases (0011) → 0000 at edge 4 and `seq_done` stays 0. Dropping `rst_req` again replays the full sequence from bit 0.
- **Reset mid-RUN:** assert `reset` for 1 cycle with `rst_req` = 0 → next edge 0000 and `seq_done` = 0. The sequence then repeats with channel 0 at edge 23 after `reset` falls.
- **Filter compiled out:** with RSTSEQ_GLITCH_FILTER_EN undefined, drop `rst_req` → channels release at edges 20, 36, 52, 68, and a 1-cycle low glitch on `rst_req` enters RELEASE.
